// File: rtl/frame_sync_ctrl.sv
// Frame sequencer for the pulse-oximeter byte stream: hunts for the sync byte,
// tracks byte position, validates the trailing checksum and strobes the
// waveform / vitals consumers. Vitals are committed only from clean frames.
`timescale 1ns/1ps
module frame_sync_ctrl #(
  parameter int unsigned FRAME_LEN   = 76,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned WAVE_FIRST  = 1,
  parameter int unsigned WAVE_LAST   = 64,
  parameter int unsigned HR_IDX      = 65,
  parameter int unsigned SPO2_IDX    = 66,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] idata,
  input  logic       idata_valid,
  output logic [7:0] wave_data,
  output logic       wave_valid,
  output logic [7:0] hr_data,
  output logic [7:0] spo2_data,
  output logic       vitals_valid,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [7:0] err_cnt,
  output logic       locked
);

  localparam int unsigned IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned GAP_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [IDX_W-1:0] L_CHK_IDX    = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] L_WAVE_FIRST = IDX_W'(WAVE_FIRST);
  localparam logic [IDX_W-1:0] L_WAVE_LAST  = IDX_W'(WAVE_LAST);
  localparam logic [IDX_W-1:0] L_HR_IDX     = IDX_W'(HR_IDX);
  localparam logic [IDX_W-1:0] L_SPO2_IDX   = IDX_W'(SPO2_IDX);
  localparam logic [GAP_W-1:0] L_GAP_LAST   = GAP_W'(TIMEOUT_CYC - 1);

  typedef enum logic {StHunt, StRecv} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic [GAP_W-1:0] r_gap;
  logic [7:0]       r_sum;
  logic [7:0]       r_hr_shadow;
  logic [7:0]       r_spo2_shadow;

  logic [7:0]       r_wave_data;
  logic             r_wave_valid;
  logic [7:0]       r_hr_data;
  logic [7:0]       r_spo2_data;
  logic             r_vitals_valid;
  logic             r_frame_ok;
  logic             r_frame_err;
  logic [7:0]       r_err_cnt;
  logic             r_locked;

  logic             w_start;
  logic             w_accept;
  logic             w_is_chk;
  logic             w_chk_good;
  logic             w_timeout;
  logic             w_is_wave;
  logic             w_err;

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= StHunt;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and per-cycle event decode.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_accept     = 1'b0;
    w_is_chk     = 1'b0;
    w_chk_good   = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      StHunt: begin
        if (idata_valid && (idata == SYNC_BYTE)) begin
          w_start      = 1'b1;
          w_state_next = StRecv;
        end
      end
      StRecv: begin
        // A byte on the expiry cycle wins over the timeout.
        if (idata_valid) begin
          w_accept = 1'b1;
          if (r_idx == L_CHK_IDX) begin
            w_is_chk     = 1'b1;
            w_chk_good   = (idata == r_sum);
            w_state_next = StHunt;
          end
        end else if (r_gap == L_GAP_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = StHunt;
        end
      end
    endcase
    w_is_wave = w_accept && (r_idx >= L_WAVE_FIRST) && (r_idx <= L_WAVE_LAST);
    w_err     = (w_is_chk && !w_chk_good) || w_timeout;
  end

  // Frame position, checksum accumulation, idle-gap tracking and shadows.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_idx         <= '0;
      r_gap         <= '0;
      r_sum         <= '0;
      r_hr_shadow   <= '0;
      r_spo2_shadow <= '0;
    end else begin
      if (w_start) begin
        r_idx <= IDX_W'(1);
        r_sum <= '0;
        r_gap <= '0;
      end else if (w_accept) begin
        r_gap <= '0;
        if (!w_is_chk) begin
          r_idx <= r_idx + 1'b1;
          r_sum <= r_sum + idata;
        end
        if (r_idx == L_HR_IDX) begin
          r_hr_shadow <= idata;
        end
        if (r_idx == L_SPO2_IDX) begin
          r_spo2_shadow <= idata;
        end
      end else if (r_state == StRecv) begin
        r_gap <= w_timeout ? '0 : r_gap + 1'b1;
      end
    end
  end

  // Registered outputs: one-cycle strobes, committed vitals, error bookkeeping.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_wave_data    <= '0;
      r_wave_valid   <= 1'b0;
      r_hr_data      <= '0;
      r_spo2_data    <= '0;
      r_vitals_valid <= 1'b0;
      r_frame_ok     <= 1'b0;
      r_frame_err    <= 1'b0;
      r_err_cnt      <= '0;
      r_locked       <= 1'b0;
    end else begin
      r_wave_valid   <= 1'b0;
      r_vitals_valid <= 1'b0;
      r_frame_ok     <= 1'b0;
      r_frame_err    <= 1'b0;
      if (w_is_wave) begin
        r_wave_data  <= idata;
        r_wave_valid <= 1'b1;
      end
      if (w_is_chk && w_chk_good) begin
        r_hr_data      <= r_hr_shadow;
        r_spo2_data    <= r_spo2_shadow;
        r_vitals_valid <= 1'b1;
        r_frame_ok     <= 1'b1;
        r_locked       <= 1'b1;
      end
      if (w_err) begin
        r_frame_err <= 1'b1;
        r_locked    <= 1'b0;
        if (r_err_cnt != 8'hFF) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end
    end
  end

  assign wave_data    = r_wave_data;
  assign wave_valid   = r_wave_valid;
  assign hr_data      = r_hr_data;
  assign spo2_data    = r_spo2_data;
  assign vitals_valid = r_vitals_valid;
  assign frame_ok     = r_frame_ok;
  assign frame_err    = r_frame_err;
  assign err_cnt      = r_err_cnt;
  assign locked       = r_locked;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Bench for frame_sync_ctrl: directed scenarios plus randomized traffic, all
// checked every cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_frame_sync_ctrl;

  localparam int unsigned FRAME_LEN = 76;
  localparam int unsigned TO_CYC    = 20;
  localparam logic [7:0]  SYNC      = 8'hA5;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [7:0] idata = 8'h00;
  logic       idata_valid = 1'b0;
  logic [7:0] wave_data;
  logic       wave_valid;
  logic [7:0] hr_data;
  logic [7:0] spo2_data;
  logic       vitals_valid;
  logic       frame_ok;
  logic       frame_err;
  logic [7:0] err_cnt;
  logic       locked;

  frame_sync_ctrl #(
    .FRAME_LEN  (FRAME_LEN),
    .SYNC_BYTE  (SYNC),
    .WAVE_FIRST (1),
    .WAVE_LAST  (64),
    .HR_IDX     (65),
    .SPO2_IDX   (66),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .idata       (idata),
    .idata_valid (idata_valid),
    .wave_data   (wave_data),
    .wave_valid  (wave_valid),
    .hr_data     (hr_data),
    .spo2_data   (spo2_data),
    .vitals_valid(vitals_valid),
    .frame_ok    (frame_ok),
    .frame_err   (frame_err),
    .err_cnt     (err_cnt),
    .locked      (locked)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  bit         m_in_frame;
  logic [7:0] m_q[$];       // bytes received after the sync byte
  int         m_idle;
  logic [7:0] m_wave_data, m_hr, m_spo2;
  bit         m_wave_valid, m_vv, m_ok, m_err, m_locked;
  int         m_cnt;

  task automatic model_clear();
    m_in_frame = 0; m_q.delete(); m_idle = 0;
    m_wave_data = 0; m_hr = 0; m_spo2 = 0; m_cnt = 0;
    m_wave_valid = 0; m_vv = 0; m_ok = 0; m_err = 0; m_locked = 0;
  endtask

  task automatic model_fail_frame();
    m_err = 1; m_locked = 0; m_in_frame = 0;
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d);
    int pos;
    int sum;
    m_wave_valid = 0; m_vv = 0; m_ok = 0; m_err = 0;
    if (!m_in_frame) begin
      if (v && d == SYNC) begin
        m_in_frame = 1; m_q.delete(); m_idle = 0;
      end
    end else if (v) begin
      m_idle = 0;
      m_q.push_back(d);
      pos = m_q.size();
      if (pos >= 1 && pos <= 64) begin
        m_wave_valid = 1; m_wave_data = d;
      end
      if (pos == FRAME_LEN - 1) begin
        sum = 0;
        for (int i = 0; i < pos - 1; i++) sum += int'(m_q[i]);
        if ((sum % 256) == int'(d)) begin
          m_hr = m_q[64]; m_spo2 = m_q[65];
          m_vv = 1; m_ok = 1; m_locked = 1; m_in_frame = 0;
        end else begin
          model_fail_frame();
        end
      end
    end else begin
      m_idle++;
      if (m_idle == TO_CYC) model_fail_frame();
    end
  endtask

  always @(posedge Clk or posedge Rst) begin
    if (Rst) model_clear();
    else model_step(idata_valid, idata);
  end

  // ---------------- per-cycle compare and pulse counters ----------------
  int c_wave = 0, c_vv = 0, c_ok = 0, c_err = 0;

  always @(negedge Clk) begin
    if (!Rst) begin
      check("outputs {wave_d,wave_v,hr,spo2,vv,ok,err,cnt,locked}",
            64'({wave_data, wave_valid, hr_data, spo2_data, vitals_valid, frame_ok, frame_err,
                 err_cnt, locked}),
            64'({m_wave_data, m_wave_valid, m_hr, m_spo2, m_vv, m_ok, m_err, 8'(m_cnt),
                 m_locked}));
      c_wave += int'(wave_valid);
      c_vv   += int'(vitals_valid);
      c_ok   += int'(frame_ok);
      c_err  += int'(frame_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] frm [FRAME_LEN];

  task automatic send(input logic [7:0] d, input int gap);
    repeat (gap) begin
      @(posedge Clk); #1;
    end
    idata = d; idata_valid = 1'b1;
    @(posedge Clk); #1;
    idata_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk); #1;
    end
  endtask

  task automatic make_std(input logic [7:0] hr, input logic [7:0] chk);
    for (int i = 0; i < FRAME_LEN; i++) frm[i] = (i >= 1 && i <= 64) ? 8'h10 : 8'h00;
    frm[0] = SYNC; frm[65] = hr; frm[66] = 8'h62; frm[75] = chk;
  endtask

  task automatic send_range(input int lo, input int hi, input int gap);
    for (int i = lo; i <= hi; i++) send(frm[i], gap);
  endtask

  int s_wave, s_vv, s_ok, s_err;
  task automatic snap();
    s_wave = c_wave; s_vv = c_vv; s_ok = c_ok; s_err = c_err;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sum8;
    #1 Rst = 1'b1;
    @(posedge Clk); @(negedge Clk);
    check("reset outputs", 64'({wave_data, wave_valid, hr_data, spo2_data, vitals_valid,
                                frame_ok, frame_err, err_cnt, locked}), 64'd0);
    @(posedge Clk); #1 Rst = 1'b0;
    idle(2);

    // 1: good frame, bytes every 3 clocks
    snap(); make_std(8'h48, 8'hAA); send_range(0, 75, 2); idle(2);
    check("s1 wave pulses", c_wave - s_wave, 64);
    check("s1 vitals pulses", c_vv - s_vv, 1);
    check("s1 frame_ok pulses", c_ok - s_ok, 1);
    check("s1 hr_data", hr_data, 72);
    check("s1 spo2_data", spo2_data, 98);
    check("s1 locked", locked, 1);
    check("s1 err_cnt", err_cnt, 0);

    // 2: bad checksum
    snap(); make_std(8'h48, 8'hAB); send_range(0, 75, 2); idle(2);
    check("s2 frame_err pulses", c_err - s_err, 1);
    check("s2 err_cnt", err_cnt, 1);
    check("s2 locked", locked, 0);
    check("s2 hr held", hr_data, 72);
    check("s2 spo2 held", spo2_data, 98);
    check("s2 vitals pulses", c_vv - s_vv, 0);

    // 3: garbage then frame with HR=0x50
    snap(); send(8'h00, 2); send(8'h37, 2); send(8'hFF, 2); idle(2);
    check("s3 garbage wave pulses", c_wave - s_wave, 0);
    snap(); make_std(8'h50, 8'hB2); send_range(0, 75, 2); idle(2);
    check("s3 frame_ok pulses", c_ok - s_ok, 1);
    check("s3 hr_data", hr_data, 80);

    // 4: timeout, then recovery, then byte landing exactly on expiry cycle
    snap(); make_std(8'h48, 8'hAA); send_range(0, 10, 0); idle(TO_CYC); idle(1);
    check("s4 timeout err pulses", c_err - s_err, 1);
    snap(); send_range(0, 75, 0); idle(2);
    check("s4 recovery frame_ok", c_ok - s_ok, 1);
    snap(); send_range(0, 10, 0); send(frm[11], TO_CYC - 1); send_range(12, 75, 0); idle(2);
    check("s4 expiry-cycle byte err pulses", c_err - s_err, 0);
    check("s4 expiry-cycle frame_ok", c_ok - s_ok, 1);

    // 5: reset mid-frame
    send_range(0, 39, 1);
    #2 Rst = 1'b1;
    #1 check("s5 outputs after async reset",
             64'({wave_data, wave_valid, hr_data, spo2_data, vitals_valid, frame_ok, frame_err,
                  err_cnt, locked}), 64'd0);
    @(posedge Clk); #1 Rst = 1'b0;
    snap(); send_range(40, 75, 0); idle(2);
    check("s5 remainder frame_ok", c_ok - s_ok, 0);
    check("s5 remainder frame_err", c_err - s_err, 0);
    snap(); send_range(0, 75, 0); idle(2);
    check("s5 next frame_ok", c_ok - s_ok, 1);
    check("s5 hr_data", hr_data, 72);

    // randomized traffic: garbage, random payloads, good/bad checksums, long gaps
    for (int f = 0; f < 40; f++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) send(8'($urandom), $urandom_range(0, 2));
      frm[0] = SYNC; sum8 = 8'h00;
      for (int i = 1; i < FRAME_LEN - 1; i++) begin
        frm[i] = 8'($urandom);
        sum8 = sum8 + frm[i];
      end
      frm[75] = ($urandom_range(0, 1) == 1) ? sum8 : sum8 + 8'd1;
      for (int i = 0; i < FRAME_LEN; i++) begin
        if ($urandom_range(0, 39) == 0) send(frm[i], $urandom_range(TO_CYC - 3, TO_CYC + 2));
        else send(frm[i], $urandom_range(0, 3));
      end
    end
    idle(TO_CYC + 5);

    // 6: saturation, then back-to-back good frames
    make_std(8'h48, 8'hAB);
    for (int f = 0; f < 260; f++) send_range(0, 75, 0);
    idle(2);
    check("s6 err_cnt saturated", err_cnt, 255);
    snap(); make_std(8'h48, 8'hAA);
    send_range(0, 75, 0); send_range(0, 75, 0); idle(2);
    check("s6 frame_ok pulses", c_ok - s_ok, 2);
    check("s6 wave pulses", c_wave - s_wave, 128);
    check("s6 locked", locked, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
